// File: rtl/spi_xfer_ctrl.sv
// SPI-slave transfer sequencer: command frame {address, rw}, then DATA_W-bit data
// frames, driving shift register, address latch, data-memory write and MISO enable.
module spi_xfer_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int BURST  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_pin,
  input  logic              sclk_pos,
  input  logic              sclk_neg,
  input  logic [ADDR_W:0]   cmd,
  output logic              shift_wren,
  output logic              sr_load,
  output logic              addr_wren,
  output logic              dm_wren,
  output logic              miso_en,
  output logic [ADDR_W-1:0] addr,
  output logic              busy
);

  localparam int MAX_BITS = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CW       = $clog2(MAX_BITS + 1);
  localparam logic [CW-1:0] CMD_LAST  = CW'(ADDR_W);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

  // Handshake: there is none; sclk_pos/sclk_neg are single-cycle event pulses and
  // cs_pin is a level. Every strobe except shift_wren is a registered-state decode.
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    CMD          = 3'd1,
    DECODE       = 3'd2,
    READ_LOAD    = 3'd3,
    READ_SHIFT   = 3'd4,
    WRITE_SHIFT  = 3'd5,
    WRITE_COMMIT = 3'd6,
    DONE         = 3'd7
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      addr  <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    addr_nxt   = addr;
    shift_wren = 1'b0;
    sr_load    = 1'b0;
    addr_wren  = 1'b0;
    dm_wren    = 1'b0;
    miso_en    = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_pin) state_nxt = CMD;
      end
      CMD: begin
        shift_wren = sclk_pos;
        if (sclk_pos) begin
          if (cnt == CMD_LAST) state_nxt = DECODE;
          else                 cnt_nxt   = cnt + 1'b1;
        end
      end
      DECODE: begin
        addr_wren = 1'b1;
        addr_nxt  = cmd[ADDR_W:1];
        state_nxt = cmd[0] ? READ_LOAD : WRITE_SHIFT;
      end
      READ_LOAD: begin
        sr_load   = 1'b1;
        miso_en   = 1'b1;
        state_nxt = READ_SHIFT;
      end
      READ_SHIFT: begin
        miso_en    = 1'b1;
        shift_wren = sclk_neg;
        if (sclk_pos) begin
          if (cnt == DATA_LAST) begin
            // Burst reloads from the next address so the load sees the new addr.
            if (BURST != 0) begin
              addr_nxt  = addr + 1'b1;
              state_nxt = READ_LOAD;
            end else begin
              state_nxt = DONE;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      WRITE_SHIFT: begin
        shift_wren = sclk_pos;
        if (sclk_pos) begin
          if (cnt == DATA_LAST) state_nxt = WRITE_COMMIT;
          else                  cnt_nxt   = cnt + 1'b1;
        end
      end
      WRITE_COMMIT: begin
        dm_wren = 1'b1;
        if (BURST != 0) begin
          addr_nxt  = addr + 1'b1;
          state_nxt = WRITE_SHIFT;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = state;
      end
      default: state_nxt = IDLE;
    endcase

    // Deselect aborts from any state; the aborting cycle has no side effects.
    if (state != IDLE && cs_pin) begin
      state_nxt  = IDLE;
      addr_nxt   = addr;
      shift_wren = 1'b0;
      sr_load    = 1'b0;
      addr_wren  = 1'b0;
      dm_wren    = 1'b0;
    end

    if (state_nxt != state) cnt_nxt = '0;
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

Parametrised SPI-slave transfer controller; successor to the fixed 8-state SPI memory FSM. It runs on the system clock and consumes conditioned SCLK edge pulses and chip-select. It sequences the shared shift register, address latch, data-memory write and MISO tri-state for a command frame of ADDR_W+1 bits ({address, rw}) followed by DATA_W-bit data frames. New behaviour:

- internal bit counter, replacing the external `reset_counter`
- internal address register
- optional burst mode that auto-increments the address per data frame until CS rises
- clean abort on mid-frame CS deassert

## Interface

Parameters:

- ADDR_W, 7, address bits in command frame
- DATA_W, 8, data bits per data frame
- BURST, 0, 1 enables multi-frame auto-increment transfers

Ports:

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- cs_pin  in  1  conditioned chip select, active-low (high = deselected)
- sclk_pos  in  1  one-clk pulse per SCLK rising edge
- sclk_neg  in  1  one-clk pulse per SCLK falling edge
- cmd  in  ADDR_W+1  low ADDR_W+1 bits of shift-register parallel out; cmd[0] = rw (1 = read), cmd[ADDR_W:1] = address
- shift_wren  out  1  shift-register shift enable
- sr_load  out  1  parallel-load shift register from data memory
- addr_wren  out  1  address latched this cycle
- dm_wren  out  1  data-memory write strobe
- miso_en  out  1  MISO driver enable
- addr  out  ADDR_W  current transfer address
- busy  out  1  state != IDLE

## Operation

States: IDLE, CMD, DECODE, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_COMMIT, DONE. The internal bit counter is wide enough for max(ADDR_W+1, DATA_W) and is cleared on every state entry.

- **IDLE:** stays while cs_pin=1. On cs_pin=0 → CMD, counter=0.
- **CMD:**
  - shift_wren = sclk_pos; the counter increments on sclk_pos.
  - On the (ADDR_W+1)th sclk_pos → DECODE.
- **DECODE** (1 clk):
  - addr_wren=1; addr ← cmd[ADDR_W:1].
  - cmd[0]=1 → READ_LOAD; else → WRITE_SHIFT.
- **READ_LOAD** (1 clk): sr_load=1, miso_en=1 → READ_SHIFT.
- **READ_SHIFT:**
  - miso_en=1; shift_wren = sclk_neg; the counter counts sclk_pos.
  - On the DATA_W-th sclk_pos: BURST=1 → addr ← addr+1, then READ_LOAD; BURST=0 → DONE.
- **WRITE_SHIFT:**
  - shift_wren = sclk_pos; the counter counts sclk_pos.
  - On the DATA_W-th → WRITE_COMMIT.
- **WRITE_COMMIT** (1 clk):
  - dm_wren=1 at the current addr.
  - BURST=1 → addr ← addr+1, then WRITE_SHIFT; BURST=0 → DONE.
- **DONE:** all strobes 0; stays until cs_pin=1 → IDLE.

Address and CS rules:

- Address increment wraps modulo 2^ADDR_W.
- cs_pin=1 in any non-IDLE state → IDLE on the next clk edge. No dm_wren, sr_load or addr change occurs that cycle; a partial write frame is discarded.
- cs_pin=1 coincident with sclk_pos/sclk_neg: CS wins, and shift_wren=0 that cycle.

## Timing

- **Reset values:** state IDLE, addr=0, counter=0, all outputs 0 (busy=0, miso_en=0).
- **Output timing:**
  - shift_wren is combinational from state & pulse (same cycle as the pulse).
  - All other strobes are Moore, exactly 1 clk wide.
- **Command latency:** with the final command sclk_pos at cycle N:
  - DECODE/addr_wren at N+1
  - addr valid at N+2
  - read: sr_load at N+2, READ_SHIFT at N+3
  - write: WRITE_SHIFT at N+2
- **Write commit:** with the final data sclk_pos at cycle M, dm_wren at M+1. In burst, addr = old+1 at M+2.
- **Read burst reload:** final data sclk_pos at M → sr_load at M+1.
- **Master constraint:** SCLK half-period ≥ 4 clk, so the load completes before the next sclk_neg.
- **Async reset mid-transfer:** immediate return to reset values; the next transfer needs a fresh CS low.

## Test plan

- **Idle hold:** cs_pin=1, 20 SCLK periods → state IDLE, busy=0, no strobes.
- **Single write:** defaults, BURST=0, cmd = {7'h15, 0}, 16 SCLK periods → one addr_wren, addr=0x15, exactly one dm_wren 1 clk after the 16th sclk_pos, then DONE until CS high.
- **Single read:** cmd = {7'h2A, 1} → sr_load 2 clk after the 8th sclk_pos, miso_en high for 8 SCLK periods, shift_wren only on sclk_neg, DONE afterwards.
- **Burst write with wrap:** BURST=1, address 0x7F, three data frames → dm_wren at addr 0x7F, 0x00, 0x01.
- **CS abort:** CS rises after 5 data bits of a write → IDLE next clk, zero dm_wren pulses, addr unchanged.
- **Reset mid-read:** reset pulsed during READ_SHIFT → all outputs 0, addr=0 in the same cycle. A subsequent write to 0x03 completes normally.
